// File: rtl/jt51_so.sv
// jt51_so: serial sound-output transmitter for a YM3012-style DAC.
// Converts signed 16-bit stereo samples to a 3-bit exponent / 10-bit mantissa
// word and shifts each 32-slot frame out LSB-first, with per-channel latch
// strobes. Left word occupies slots 0-15, right word slots 16-31.
// Optional feature: define JT51_SO_ROUND_EN to round the mantissa
// (saturating) instead of truncating it.
module jt51_so (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        load,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        so,
    output logic        sh1,
    output logic        sh2,
    output logic        ovf,
    output logic        unf,
    output logic        busy
);

    // Linear sample to 16-bit serial word: [2:0]=0, [12:3]=mantissa, [15:13]=exponent
    function automatic logic [15:0] enc(input logic [15:0] lin);
        logic [2:0]         e;
        logic [9:0]         man;
        logic signed [15:0] t;
        e = 3'd7;
        // pick the smallest exponent whose upper bits are pure sign extension
        for (int k = 7; k >= 1; k--) begin
            t = $signed(lin) >>> (k + 8);
            if (t == 16'sd0 || t == -16'sd1) e = 3'(k);
        end
        man = 10'(lin >> (e - 3'd1));
`ifdef JT51_SO_ROUND_EN
        // only +511 can overflow when adding one; negative values never wrap
        if (e >= 3'd2 && lin[{1'b0, e} - 4'd2] && man != 10'h1FF)
            man = man + 10'd1;
`endif
        enc = {e, man, 3'b000};
    endfunction

    logic [31:0] new_word;
    logic [31:0] hold;
    logic [31:0] sr;
    logic [4:0]  slot;
    logic        run;
    logic        pending;

    assign new_word = {enc(right), enc(left)};
    assign busy     = run;

    // Frame sequencer: slot counter, double buffer and rotating shift register.
    // The shift register rotates, so after 32 ticks it holds the same frame
    // again, which is what gets retransmitted on underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            slot    <= 5'd0;
            pending <= 1'b0;
            hold    <= 32'd0;
            sr      <= 32'd0;
            so      <= 1'b0;
            sh1     <= 1'b0;
            sh2     <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (cen) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (!run) begin
                if (load) begin
                    run  <= 1'b1;
                    sr   <= new_word;
                    hold <= new_word;
                    slot <= 5'd0;
                end
            end else begin
                so   <= sr[0];
                sh1  <= slot[4:2] == 3'b011;
                sh2  <= slot[4:2] == 3'b111;
                slot <= slot + 5'd1;
                if (slot == 5'd31) begin
                    if (load) begin
                        sr      <= new_word;
                        hold    <= new_word;
                        pending <= 1'b0;
                    end else if (pending) begin
                        sr      <= hold;
                        pending <= 1'b0;
                    end else begin
                        sr  <= {sr[0], sr[31:1]};
                        unf <= 1'b1;
                    end
                end else begin
                    sr <= {sr[0], sr[31:1]};
                    if (load) begin
                        hold    <= new_word;
                        pending <= 1'b1;
                        ovf     <= pending;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jt51_so.sv
// tb_jt51_so: randomized bench for jt51_so against a frame-level model.
module tb_jt51_so;

    logic        rst, clk, cen, load;
    logic [15:0] left, right;
    logic        so, sh1, sh2, ovf, unf, busy;

    int checks = 0;
    int errors = 0;

    jt51_so dut (
        .rst(rst), .clk(clk), .cen(cen), .load(load),
        .left(left), .right(right),
        .so(so), .sh1(sh1), .sh2(sh2), .ovf(ovf), .unf(unf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    bit          m_run, m_pend, m_so, m_sh1, m_sh2, m_ovf, m_unf;
    int          m_slot;
    logic [31:0] m_fr;
    logic [15:0] m_hl, m_hr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // word from the numeric rules: exponent from the representable range,
    // mantissa as floor(v / 2^(e-1)) kept to 10 bits
    function automatic logic [15:0] word(input logic [15:0] x);
        int v, e, man;
        v = int'($signed(x));
        e = 7;
        for (int k = 7; k >= 1; k--)
            if (v >= -(1 << (k + 8)) && v < (1 << (k + 8))) e = k;
        man = v >>> (e - 1);
`ifdef JT51_SO_ROUND_EN
        if (e >= 2 && ((v >>> (e - 2)) & 1) == 1) man = man + 1;
        if (man > 511) man = 511;
`endif
        word = 16'((e << 13) | ((man & 1023) << 3));
    endfunction

    function automatic logic [31:0] frame(input logic [15:0] l, input logic [15:0] r);
        frame = {word(r), word(l)};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_so = 0; m_sh1 = 0; m_sh2 = 0;
        m_ovf = 0; m_unf = 0; m_slot = 0; m_fr = '0; m_hl = '0; m_hr = '0;
    endtask

    task automatic model_step(input bit l, input logic [15:0] lv, input logic [15:0] rv);
        m_ovf = 0;
        m_unf = 0;
        if (!m_run) begin
            if (l) begin
                m_run  = 1;
                m_fr   = frame(lv, rv);
                m_slot = 0;
            end
        end else begin
            m_so  = m_fr[m_slot];
            m_sh1 = (m_slot >= 12 && m_slot <= 15);
            m_sh2 = (m_slot >= 28);
            if (m_slot == 31) begin
                if (l) begin
                    m_fr = frame(lv, rv); m_pend = 0;
                end else if (m_pend) begin
                    m_fr = frame(m_hl, m_hr); m_pend = 0;
                end else begin
                    m_unf = 1;
                end
            end else if (l) begin
                m_ovf  = m_pend;
                m_hl   = lv;
                m_hr   = rv;
                m_pend = 1;
            end
            m_slot = (m_slot + 1) % 32;
        end
    endtask

    task automatic chk_all();
        chk("so",   32'(so),   32'(m_so));
        chk("sh1",  32'(sh1),  32'(m_sh1));
        chk("sh2",  32'(sh2),  32'(m_sh2));
        chk("ovf",  32'(ovf),  32'(m_ovf));
        chk("unf",  32'(unf),  32'(m_unf));
        chk("busy", 32'(busy), 32'(m_run));
    endtask

    task automatic tick(input bit c, input bit l, input logic [15:0] lv, input logic [15:0] rv);
        cen = c; load = l; left = lv; right = rv;
        @(posedge clk);
        if (c) model_step(l, lv, rv);
        #1;
        chk_all();
        load = 1'b0;
    endtask

    task automatic run_idle(input int n, input bit rnd_cen);
        for (int i = 0; i < n; i++)
            tick(rnd_cen ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    // advance with cen=1 until the model is about to process slot s
    task automatic wait_slot(input int s);
        int n;
        n = 0;
        while (!(m_run && m_slot == s) && n < 70) begin
            tick(1'b1, 1'b0, 16'd0, 16'd0);
            n++;
        end
        chk("wait_slot", 32'(m_run && m_slot == s), 32'd1);
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] x;
        x = 16'($urandom);
        rnd16 = 16'($signed(x) >>> $urandom_range(0, 15));
    endfunction

    logic [15:0] dl [5] = '{16'h0100, 16'h7FFF, 16'h0622, 16'h8000, 16'hFE00};
    logic [15:0] dr [5] = '{16'hFFFF, 16'h4000, 16'h0000, 16'h00FF, 16'h0200};

    initial begin
        rst = 1'b1; cen = 1'b0; load = 1'b0; left = '0; right = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;

        // idle: nothing moves without a load
        run_idle(6, 1'b0);

        // directed samples; each followed by more than a frame of no loads
        for (int i = 0; i < 5; i++) begin
            if (m_run) wait_slot($urandom_range(0, 30));
            tick(1'b1, 1'b1, dl[i], dr[i]);
            run_idle(75, i[0]);
        end

        // two loads in one frame: overrun, second sample wins
        wait_slot(3);
        tick(1'b1, 1'b1, 16'h1234, 16'hABCD);
        run_idle(5, 1'b0);
        tick(1'b1, 1'b1, 16'h0622, 16'hC000);
        run_idle(80, 1'b0);

        // load exactly on the slot-31 tick
        wait_slot(31);
        tick(1'b1, 1'b1, 16'h3333, 16'hF00F);
        run_idle(40, 1'b0);

        // randomized traffic with gapped cen
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rnd16(), rnd16());

        // reset mid-frame: outputs clear without waiting for a clock
        wait_slot(20);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;
        run_idle(40, 1'b0);
        tick(1'b1, 1'b1, 16'h0100, 16'hFFFF);
        run_idle(40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
